m_stage_mem_ctrl: RTL and testbench

- Memory-stage access controller between the EM pipeline register and the MW pipeline register.
- Turns the M-stage load/store op into a multi-cycle request on the data-memory bus, including byte enables and lane alignment.
- Holds the pipeline with `mem_stall` until the bus completes, then presents the extended load data as M_MEM_read_data for MW capture.
- A timeout counter guards against a bus that never answers.

---
 rtl/m_stage_mem_ctrl_pkg.sv | 25 ++
 rtl/m_stage_mem_ctrl_lane_align.sv | 73 +++++++
 rtl/m_stage_mem_ctrl.sv | 130 +++++++++++++
 tb/tb_m_stage_mem_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_stage_mem_ctrl_pkg.sv
// Shared encodings for the M-stage memory controller: memory-op codes and FSM states.
package m_stage_mem_ctrl_pkg;

  localparam logic [3:0] MEM_OP_NONE = 4'd0;
  localparam logic [3:0] MEM_OP_LW   = 4'd1;
  localparam logic [3:0] MEM_OP_LH   = 4'd2;
  localparam logic [3:0] MEM_OP_LHU  = 4'd3;
  localparam logic [3:0] MEM_OP_LB   = 4'd4;
  localparam logic [3:0] MEM_OP_LBU  = 4'd5;
  localparam logic [3:0] MEM_OP_SW   = 4'd6;
  localparam logic [3:0] MEM_OP_SH   = 4'd7;
  localparam logic [3:0] MEM_OP_SB   = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  // True for the three store encodings; everything else that is not NONE is a load.
  function automatic logic op_is_store(input logic [3:0] op);
    return (op == MEM_OP_SW) || (op == MEM_OP_SH) || (op == MEM_OP_SB);
  endfunction

endpackage

// File: rtl/m_stage_mem_ctrl_lane_align.sv
// Combinational lane logic: byte enables, store replication, load extraction/extension
// and misalignment detection for one M-stage memory op.
module mem_lane_align
  import m_stage_mem_ctrl_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] cap_word_i,
  output logic [3:0]  byteen_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o,
  output logic        misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // The lane picked from the captured word depends only on the low address bits.
  assign byte_sel = cap_word_i[{addr_lo_i, 3'b000} +: 8];
  assign half_sel = addr_lo_i[1] ? cap_word_i[31:16] : cap_word_i[15:0];

  // Decode access size into enables, replicated write data and extended read data.
  always_comb begin
    byteen_o    = 4'b0000;
    wdata_o     = 32'h0;
    load_data_o = 32'h0;
    misalign_o  = 1'b0;
    case (op_i)
      MEM_OP_LW: begin
        misalign_o  = (addr_lo_i != 2'b00);
        byteen_o    = 4'b1111;
        load_data_o = cap_word_i;
      end
      MEM_OP_SW: begin
        misalign_o = (addr_lo_i != 2'b00);
        byteen_o   = 4'b1111;
        wdata_o    = store_data_i;
      end
      MEM_OP_LH: begin
        misalign_o  = addr_lo_i[0];
        byteen_o    = 4'b0011 << addr_lo_i;
        load_data_o = {{16{half_sel[15]}}, half_sel};
      end
      MEM_OP_LHU: begin
        misalign_o  = addr_lo_i[0];
        byteen_o    = 4'b0011 << addr_lo_i;
        load_data_o = {16'h0, half_sel};
      end
      MEM_OP_SH: begin
        misalign_o = addr_lo_i[0];
        byteen_o   = 4'b0011 << addr_lo_i;
        wdata_o    = {2{store_data_i[15:0]}};
      end
      MEM_OP_LB: begin
        byteen_o    = 4'b0001 << addr_lo_i;
        load_data_o = {{24{byte_sel[7]}}, byte_sel};
      end
      MEM_OP_LBU: begin
        byteen_o    = 4'b0001 << addr_lo_i;
        load_data_o = {24'h0, byte_sel};
      end
      MEM_OP_SB: begin
        byteen_o = 4'b0001 << addr_lo_i;
        wdata_o  = {4{store_data_i[7:0]}};
      end
      default: ;
    endcase
    // A misaligned op never reaches the bus and must not leak stale capture data.
    if (misalign_o) load_data_o = 32'h0;
  end

endmodule

// File: rtl/m_stage_mem_ctrl.sv
// M-stage memory access controller: issues a registered bus request for each aligned
// load/store, stalls the pipeline until the bus answers or times out, then holds the
// extended load result for one DONE cycle so MW can capture it.
module m_stage_mem_ctrl
  import m_stage_mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  M_mem_op,
  input  logic [31:0] M_ALU_result,
  input  logic [31:0] M_store_data,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byteen,
  output logic [31:0] bus_wdata,
  output logic        mem_stall,
  output logic [31:0] M_MEM_read_data,
  output logic        mem_misalign,
  output logic        bus_err
);

  mem_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       cap_q;
  logic              req_q;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [3:0]        byteen_q;
  logic [31:0]       wdata_q;
  logic              err_q;

  logic [3:0]        lane_byteen;
  logic [31:0]       lane_wdata;
  logic [31:0]       lane_rdata;
  logic              lane_misalign;
  logic              start_access;
  logic              timeout_hit;

  mem_lane_align u_lane (
    .op_i         (M_mem_op),
    .addr_lo_i    (M_ALU_result[1:0]),
    .store_data_i (M_store_data),
    .cap_word_i   (cap_q),
    .byteen_o     (lane_byteen),
    .wdata_o      (lane_wdata),
    .load_data_o  (lane_rdata),
    .misalign_o   (lane_misalign)
  );

  assign start_access = (M_mem_op != MEM_OP_NONE) && !lane_misalign;
  assign timeout_hit  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Stall is combinational: an op arriving in IDLE must freeze the pipeline that same cycle.
  always_comb begin
    mem_stall = 1'b0;
    case (state_q)
      IDLE:    mem_stall = start_access;
      BUSY:    mem_stall = 1'b1;
      default: mem_stall = 1'b0;
    endcase
  end

  // FSM with the timeout counter, capture register and all registered bus outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cap_q    <= 32'h0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      byteen_q <= 4'b0000;
      wdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (start_access) begin
            state_q  <= BUSY;
            req_q    <= 1'b1;
            we_q     <= op_is_store(M_mem_op);
            addr_q   <= {M_ALU_result[31:2], 2'b00};
            byteen_q <= lane_byteen;
            wdata_q  <= lane_wdata;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          if (bus_ready) begin
            // A response on the timeout cycle still counts as a normal completion.
            if (!we_q) cap_q <= bus_rdata;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            byteen_q <= 4'b0000;
            state_q  <= DONE;
          end else if (timeout_hit) begin
            err_q    <= 1'b1;
            if (!we_q) cap_q <= 32'h0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            byteen_q <= 4'b0000;
            state_q  <= DONE;
          end
        end
        DONE: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_req         = req_q;
  assign bus_we          = we_q;
  assign bus_addr        = addr_q;
  assign bus_byteen      = byteen_q;
  assign bus_wdata       = wdata_q;
  assign bus_err         = err_q;
  assign mem_misalign    = lane_misalign;
  assign M_MEM_read_data = lane_rdata;

endmodule

// File: tb/tb_m_stage_mem_ctrl.sv
// Scoreboard bench for m_stage_mem_ctrl: the driver pushes expected requests and
// responses, a negedge monitor pops and compares them whenever the bus shows activity.
module tb_m_stage_mem_ctrl;
  import m_stage_mem_ctrl_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  M_mem_op = MEM_OP_NONE;
  logic [31:0] M_ALU_result = 32'h0;
  logic [31:0] M_store_data = 32'h0;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_req, bus_we, mem_stall, mem_misalign, bus_err;
  logic [31:0] bus_addr, bus_wdata, M_MEM_read_data;
  logic [3:0]  bus_byteen;

  m_stage_mem_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .M_mem_op(M_mem_op), .M_ALU_result(M_ALU_result),
    .M_store_data(M_store_data), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_byteen(bus_byteen),
    .bus_wdata(bus_wdata), .mem_stall(mem_stall), .M_MEM_read_data(M_MEM_read_data),
    .mem_misalign(mem_misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd;
  } req_t;

  typedef struct {
    logic        ld;
    logic [31:0] data;
    logic        err;
    int          busy;
  } resp_t;

  req_t  req_q[$];
  resp_t resp_q[$];
  int    checks = 0;
  int    failures = 0;
  logic  exp_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int op_size(input logic [3:0] op);
    case (op)
      MEM_OP_LW, MEM_OP_SW:              return 4;
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH:  return 2;
      default:                           return 1;
    endcase
  endfunction

  function automatic bit is_store(input logic [3:0] op);
    return op == MEM_OP_SW || op == MEM_OP_SH || op == MEM_OP_SB;
  endfunction

  function automatic bit misaligned(input logic [3:0] op, input logic [31:0] addr);
    return (int'(addr[1:0]) % op_size(op)) != 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [3:0] op, input logic [31:0] addr);
    int m;
    m = ((1 << op_size(op)) - 1) << int'(addr[1:0]);
    return m[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [3:0] op, input logic [31:0] sd);
    logic [31:0] w;
    logic [31:0] b;
    w = 32'h0;
    for (int i = 0; i < 4; i++) begin
      b = (sd >> (8 * (i % op_size(op)))) & 32'hFF;
      w = w | (b << (8 * i));
    end
    return w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] addr,
                                           input logic [31:0] w);
    logic [31:0] v;
    v = w >> (8 * int'(addr[1:0]));
    if (op_size(op) == 1) v = v & 32'hFF;
    else if (op_size(op) == 2) v = v & 32'hFFFF;
    if (op == MEM_OP_LB && v >= 32'd128) v = v - 32'd256;
    if (op == MEM_OP_LH && v >= 32'd32768) v = v - 32'd65536;
    return v;
  endfunction

  // ---------------- driver ----------------
  // Presents one op in IDLE, plays the bus (ready after 'delay' BUSY cycles, never if
  // delay >= TO) and returns at the start of the DONE cycle (or the IDLE cycle if misaligned).
  task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                       input logic [31:0] rd, input int delay);
    req_t  rq;
    resp_t rs;
    @(posedge clk); #1;
    M_mem_op = op; M_ALU_result = addr; M_store_data = sd;
    bus_ready = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
    if (misaligned(op, addr)) begin
      #1;
      chk("misalign_flag", 32'(mem_misalign), 32'd1);
      chk("misalign_stall", 32'(mem_stall), 32'd0);
      chk("misalign_rdata", M_MEM_read_data, 32'h0);
      return;
    end
    rq.addr = {addr[31:2], 2'b00}; rq.we = is_store(op);
    rq.be = ref_be(op, addr); rq.wd = ref_wdata(op, sd);
    req_q.push_back(rq);
    if (delay >= TO) exp_err = 1'b1;
    rs.ld = !is_store(op);
    rs.data = (delay >= TO) ? 32'h0 : ref_load(op, addr, rd);
    rs.err = exp_err;
    rs.busy = (delay >= TO) ? TO : delay + 1;
    resp_q.push_back(rs);
    #1;
    chk("idle_stall", 32'(mem_stall), 32'd1);
    chk("idle_misalign", 32'(mem_misalign), 32'd0);
    @(posedge clk); #1;
    for (int k = 0; ; k++) begin
      bus_ready = (k == delay);
      bus_rdata = (k == delay) ? rd : $urandom;
      @(posedge clk); #1;
      if (k == delay || k == TO - 1) break;
    end
    bus_ready = 1'($urandom_range(0, 1));
    bus_rdata = $urandom;
  endtask

  // ---------------- monitor ----------------
  req_t cur;
  int   busy_cnt = 0;
  bit   prev_req = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      prev_req = 1'b0;
      busy_cnt = 0;
    end else begin
      if (bus_req && !prev_req) begin
        if (req_q.size() == 0) chk("req_unexpected", 32'(bus_req), 32'd0);
        else begin
          cur = req_q.pop_front();
          chk("req_addr", bus_addr, cur.addr);
          chk("req_we", 32'(bus_we), 32'(cur.we));
          chk("req_byteen", 32'(bus_byteen), 32'(cur.be));
          if (cur.we) chk("req_wdata", bus_wdata, cur.wd);
        end
        busy_cnt = 0;
      end else if (bus_req) begin
        chk("hold_addr", bus_addr, cur.addr);
        chk("hold_we", 32'(bus_we), 32'(cur.we));
        chk("hold_byteen", 32'(bus_byteen), 32'(cur.be));
        if (cur.we) chk("hold_wdata", bus_wdata, cur.wd);
      end
      if (bus_req) begin
        chk("busy_stall", 32'(mem_stall), 32'd1);
        busy_cnt++;
      end
      if (!bus_req && prev_req) begin
        chk("done_stall", 32'(mem_stall), 32'd0);
        if (resp_q.size() == 0) chk("resp_unexpected", 32'd1, 32'd0);
        else begin
          resp_t rs;
          rs = resp_q.pop_front();
          chk("done_busy_cycles", 32'(busy_cnt), 32'(rs.busy));
          chk("done_bus_err", 32'(bus_err), 32'(rs.err));
          if (rs.ld) chk("done_rdata", M_MEM_read_data, rs.data);
        end
      end
      prev_req = bus_req;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] ops [8];
    ops = '{MEM_OP_LW, MEM_OP_LH, MEM_OP_LHU, MEM_OP_LB, MEM_OP_LBU,
            MEM_OP_SW, MEM_OP_SH, MEM_OP_SB};
    #12;
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_we", 32'(bus_we), 32'd0);
    chk("rst_byteen", 32'(bus_byteen), 32'd0);
    chk("rst_wdata", bus_wdata, 32'h0);
    chk("rst_err", 32'(bus_err), 32'd0);
    chk("rst_rdata", M_MEM_read_data, 32'h0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #3 reset = 1'b1;

    do_op(MEM_OP_LW,  32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0);
    do_op(MEM_OP_LB,  32'h0000_2003, 32'h0, 32'h80FF_FFFF, 0);
    do_op(MEM_OP_LBU, 32'h0000_2003, 32'h0, 32'h80FF_FFFF, 1);
    do_op(MEM_OP_SH,  32'h0000_3002, 32'h1234_ABCD, 32'h0, 2);
    do_op(MEM_OP_LW,  32'h0000_1002, 32'h0, 32'h0, 0);
    do_op(MEM_OP_LH,  32'h0000_1001, 32'h0, 32'h0, 0);
    do_op(MEM_OP_LH,  32'h0000_4002, 32'h0, 32'h8001_7FFF, TO - 1);
    do_op(MEM_OP_LW,  32'h0000_5000, 32'h0, 32'h1111_2222, 99);
    do_op(MEM_OP_LW,  32'h0000_6008, 32'h0, 32'hCAFE_F00D, 0);

    for (int n = 0; n < 40; n++) begin
      logic [3:0]  op;
      logic [31:0] a;
      int          d;
      op = ops[$urandom_range(0, 7)];
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(op_size(op) - 1));
      d  = ($urandom_range(0, 9) == 0) ? 40 : $urandom_range(0, 5);
      do_op(op, a, $urandom, $urandom, d);
    end

    // Abandon a load in its second BUSY cycle with an asynchronous reset.
    do_op(MEM_OP_LW, 32'h0000_7000, 32'h0, 32'hDEAD_BEEF, 0);
    @(posedge clk); #1;
    M_mem_op = MEM_OP_LW; M_ALU_result = 32'h0000_7004; bus_ready = 1'b0;
    req_q.push_back('{addr: 32'h0000_7004, we: 1'b0, be: 4'hF, wd: 32'h0});
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_req", 32'(bus_req), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("async_rst_req", 32'(bus_req), 32'd0);
    chk("async_rst_byteen", 32'(bus_byteen), 32'd0);
    chk("async_rst_err", 32'(bus_err), 32'd0);
    chk("async_rst_cap", M_MEM_read_data, 32'h0);
    M_mem_op = MEM_OP_NONE;
    req_q.delete();
    resp_q.delete();
    exp_err = 1'b0;
    @(posedge clk);
    @(posedge clk); #3 reset = 1'b1;

    do_op(MEM_OP_LHU, 32'h0000_8002, 32'h0, 32'hBEEF_0000, 1);
    do_op(MEM_OP_SB,  32'h0000_9001, 32'h0000_005A, 32'h0, 0);
    @(posedge clk); #1 M_mem_op = MEM_OP_NONE; bus_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("final_req_q_empty", 32'(req_q.size()), 32'd0);
    chk("final_resp_q_empty", 32'(resp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
